// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the instruction-memory responder
package mips_mem_pkg;

  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Fetch handshake states: idle, counting wait states, driving the response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

  // Width of a word index for a memory of the given depth (at least one bit)
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - packs boot bytes big-endian into words and tracks the write pointer
module imem_byte_packer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load_valid,
  input  logic [7:0]         load_byte,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_done,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word_data,
  output logic [IDX_W-1:0]   word_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               done_q, done_d;
  logic [INSTR_W-1:0] part_q, part_d;
  logic [INSTR_W-1:0] merged;
  logic               accept;

  assign accept     = load_valid && !done_q;
  assign load_ready = !done_q;
  assign load_done  = done_q;
  assign word_idx   = wr_ptr_q;
  assign word_data  = merged;

  // Drop the incoming byte into its big-endian lane; unfilled lanes stay zero
  always_comb begin
    merged = part_q;
    case (byte_cnt_q)
      2'd0:    merged[31:24] = load_byte;
      2'd1:    merged[23:16] = load_byte;
      2'd2:    merged[15:8]  = load_byte;
      default: merged[7:0]   = load_byte;
    endcase
  end

  // Loader sequencing: restart on clear, emit a word on the 4th byte or on load_last
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    done_d     = done_q;
    part_d     = part_q;
    word_valid = 1'b0;
    if (clear) begin
      byte_cnt_d = 2'd0;
      wr_ptr_d   = '0;
      done_d     = 1'b0;
      part_d     = '0;
    end else if (accept) begin
      if (byte_cnt_q == 2'd3 || load_last) begin
        word_valid = 1'b1;
        byte_cnt_d = 2'd0;
        part_d     = '0;
        if (load_last || wr_ptr_q == LAST_IDX) begin
          done_d = 1'b1;
        end
        // The last slot ends the image, so the pointer parks there instead of wrapping
        if (wr_ptr_q != LAST_IDX) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        part_d     = merged;
      end
    end
  end

  // Loader state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q <= 2'd0;
      wr_ptr_q   <= '0;
      done_q     <= 1'b0;
      part_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      done_q     <= done_d;
      part_q     <= part_d;
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - instruction memory with wait-state fetch handshake and boot loader
module imem_fetch_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ack,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic               fetch_err,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [7:0]         load_byte,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_done
);

  localparam int         IDX_W     = idx_width(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  fetch_state_e       state_q, state_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ack_q, ack_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               err_q, err_d;

  logic [INSTR_W-1:0] mem [DEPTH_WORDS];

  logic               clear;
  logic               word_valid;
  logic [INSTR_W-1:0] word_data;
  logic [IDX_W-1:0]   word_idx;
  logic [ADDR_W-3:0]  word_sel;
  logic               addr_bad;

  // A restart is honoured only between transactions; otherwise it is dropped
  assign clear = load_start && (state_q == IDLE);

  imem_byte_packer #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .load_valid(load_valid),
    .load_byte (load_byte),
    .load_last (load_last),
    .load_ready(load_ready),
    .load_done (load_done),
    .word_valid(word_valid),
    .word_data (word_data),
    .word_idx  (word_idx)
  );

  // Instruction storage, written only by the boot loader and never reset
  always_ff @(posedge clk) begin
    if (word_valid) begin
      mem[word_idx] <= word_data;
    end
  end

  // Fetch FSM state register plus latched address and registered response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      ack_q      <= 1'b0;
      instr_q    <= NOP_INSTR;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      ack_q      <= ack_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
    end
  end

  // Next-state: accept a request once loaded, count wait states, respond once
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (fetch_req && load_done && !load_start) begin
          addr_d = fetch_addr;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address decode of the latched fetch address
  always_comb begin
    word_sel = addr_q[ADDR_W-1:2];
    addr_bad = (addr_q[1:0] != 2'b00) || (int'(word_sel) >= DEPTH_WORDS);
  end

  // Outputs: the response is registered so ack lands the cycle after RESP
  always_comb begin
    ack_d   = 1'b0;
    instr_d = instr_q;
    err_d   = err_q;
    if (state_q == RESP) begin
      ack_d = 1'b1;
      if (addr_bad) begin
        instr_d = NOP_INSTR;
        err_d   = 1'b1;
      end else begin
        instr_d = mem[word_sel[IDX_W-1:0]];
        err_d   = 1'b0;
      end
    end
  end

  assign fetch_ack   = ack_q;
  assign fetch_instr = instr_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - randomized self-checking bench for imem_fetch_responder
module tb_imem_fetch_responder;

  localparam int DEPTH = 48;
  localparam int WS    = 1;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_addr = 8'h00;
  logic        fetch_ack;
  logic [31:0] fetch_instr;
  logic        fetch_err;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_mem [64];
  logic [7:0]  img [$];

  imem_fetch_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_instr(fetch_instr),
    .fetch_err  (fetch_err),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference loader: bytes fill words MSB first, last byte pads, full memory ends the image
  task automatic model_load(input bit with_last);
    int          wp = 0;
    int          bc = 0;
    logic [31:0] w = 32'h0;
    bit          done = 1'b0;
    for (int i = 0; i < img.size(); i++) begin
      if (done) break;
      w = w | (32'(img[i]) << (8 * (3 - bc)));
      bc++;
      if (bc == 4 || (with_last && i == img.size() - 1)) begin
        exp_mem[wp] = w;
        if (wp == DEPTH - 1) done = 1'b1;
        wp++;
        bc = 0;
        w  = 32'h0;
      end
    end
  endtask

  function automatic void fetch_exp(input logic [7:0] a, output logic [31:0] ei, output logic ee);
    if (a % 4 != 0 || (a / 4) >= DEPTH) begin
      ei = 32'h0;
      ee = 1'b1;
    end else begin
      ei = exp_mem[a / 4];
      ee = 1'b0;
    end
  endfunction

  // Streams img one byte per cycle starting at the current negedge
  task automatic load_img(input bit with_last);
    for (int i = 0; i < img.size(); i++) begin
      load_valid = 1'b1;
      load_byte  = img[i];
      load_last  = with_last && (i == img.size() - 1);
      if (i == img.size() - 1) chk("done_before_last", 32'(load_done), 32'd0);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    model_load(with_last);
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("start_clears_done", 32'(load_done), 32'd0);
    chk("start_ready", 32'(load_ready), 32'd1);
  endtask

  // Mode 1 drops req, mode 2 changes addr, mode 3 pulses load_start while in flight
  task automatic wait_ack(input logic [31:0] ei, input logic ee, input int mode);
    int cyc = 0;
    bit got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (fetch_ack) got = 1'b1;
      else if (cyc == 1) begin
        if (mode == 1) fetch_req = 1'b0;
        if (mode == 2) fetch_addr = 8'($urandom);
        if (mode == 3) load_start = 1'b1;
      end else if (cyc == 2) load_start = 1'b0;
    end
    load_start = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(cyc), 32'(WS + 2));
    chk("instr", fetch_instr, ei);
    chk("err", 32'(fetch_err), 32'(ee));
  endtask

  task automatic do_fetch(input logic [7:0] a, input int mode, input bit keep);
    logic [31:0] ei;
    logic        ee;
    fetch_req  = 1'b1;
    fetch_addr = a;
    fetch_exp(a, ei, ee);
    wait_ack(ei, ee, mode);
    if (!keep) begin
      fetch_req = 1'b0;
      @(negedge clk);
      chk("ack_one_pulse", 32'(fetch_ack), 32'd0);
    end
    if (mode == 3) chk("start_dropped", 32'(load_done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          seen;
    logic [7:0]  a;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(fetch_ack), 32'd0);
    chk("rst_instr", fetch_instr, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic 8-byte image
    img = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    load_img(1'b1);
    chk("img8_done", 32'(load_done), 32'd1);
    chk("img8_ready", 32'(load_ready), 32'd0);
    chk("img8_model1", exp_mem[1], 32'h0022_1820);
    do_fetch(8'h04, 0, 1'b1);
    do_fetch(8'h00, 0, 1'b0);
    do_fetch(8'h06, 0, 1'b0);
    do_fetch(8'hC0, 0, 1'b0);

    // Whole memory without load_last, then a rejected extra byte
    pulse_load_start();
    img = {};
    for (int i = 0; i < DEPTH * 4; i++) img.push_back(8'($urandom));
    load_img(1'b0);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_byte  = 8'hFF;
    load_last  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("extra_done", 32'(load_done), 32'd1);
    do_fetch(8'hBC, 0, 1'b0);
    do_fetch(8'hC0, 0, 1'b0);
    do_fetch(8'h00, 0, 1'b0);

    // Random partial reloads and random fetches with protocol abuse
    for (int r = 0; r < 3; r++) begin
      pulse_load_start();
      img = {};
      for (int i = 0; i < int'($urandom_range(1, 80)); i++) img.push_back(8'($urandom));
      load_img(1'b1);
      for (int k = 0; k < 15; k++) begin
        a = 8'($urandom);
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        do_fetch(a, int'($urandom_range(0, 3)), 1'b0);
      end
    end

    // Request held while unloaded stalls until the image completes
    pulse_load_start();
    fetch_req  = 1'b1;
    fetch_addr = 8'h00;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (fetch_ack) seen = 1'b1;
    end
    chk("stall_no_ack", 32'(seen), 32'd0);
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_img(1'b1);
    wait_ack(32'h1122_3344, 1'b0, 0);
    fetch_req = 1'b0;
    @(negedge clk);

    // load_start coinciding with a request wins
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 8'h00;
    @(negedge clk);
    load_start = 1'b0;
    chk("coinc_done", 32'(load_done), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (fetch_ack) seen = 1'b1;
    end
    chk("coinc_no_ack", 32'(seen), 32'd0);
    fetch_req = 1'b0;

    // Short image is zero padded
    img = '{8'hAA, 8'hBB, 8'hCC};
    load_img(1'b1);
    chk("pad_model", exp_mem[0], 32'hAABB_CC00);
    do_fetch(8'h00, 0, 1'b0);

    // Asynchronous reset during WAIT
    fetch_req  = 1'b1;
    fetch_addr = 8'h00;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ack", 32'(fetch_ack), 32'd0);
    chk("arst_instr", fetch_instr, 32'h0);
    chk("arst_err", 32'(fetch_err), 32'd0);
    chk("arst_done", 32'(load_done), 32'd0);
    chk("arst_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (fetch_ack) seen = 1'b1;
    end
    chk("arst_no_ack", 32'(seen), 32'd0);
    chk("arst_still_unloaded", 32'(load_done), 32'd0);
    fetch_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
